roberts_mdc_engine_ctrl: RTL
============================

# roberts_mdc_engine_ctrl

Engine-side control and stream stage for the Roberts MDC accelerator. It sits between the HWPE control FSM and the multi-dataflow core. It consumes the FSM's engine controls (clear / enable / start / output limit) and returns the engine flags (ready, done, output count). It gates the `in_pel` and `in_size` streams into the core and buffers the core's `out_pel` results in a 2-entry FIFO before they reach the sink streamer. It counts accepted output pixels against the programmed limit.

## Interface
Reset is asynchronous, active-high (`rst_i`). There is one clock (`clk_i`).

Parameters:
- `DATA_WIDTH`, 32: width of every stream data bus.
- `CNT_WIDTH`, 32: width of the limit and count.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: async reset, active-high.
- `eng_clear_i`, in, 1: synchronous clear of engine state (FSM `ctrl_engine.clear`).
- `eng_enable_i`, in, 1: stream enable; 0 freezes all handshakes.
- `eng_start_i`, in, 1: start request; honoured only in IDLE.
- `cnt_limit_i`, in, `CNT_WIDTH`: number of output pixels per job; sampled at start.
- `eng_ready_o`, out, 1: engine idle and able to accept start.
- `eng_done_o`, out, 1: one-cycle pulse when the count reaches the limit.
- `cnt_out_pel_o`, out, `CNT_WIDTH`: accepted output pixels in the current job.
- `in_pel_valid_i`, in, 1; `in_pel_ready_o`, out, 1; `in_pel_data_i`, in, `DATA_WIDTH`: input pixel stream from the source streamer.
- `in_size_valid_i`, in, 1; `in_size_ready_o`, out, 1; `in_size_data_i`, in, `DATA_WIDTH`: image-size stream from the source streamer.
- `core_in_pel_valid_o`, out, 1; `core_in_pel_ready_i`, in, 1; `core_in_pel_data_o`, out, `DATA_WIDTH`: pixel stream to the core.
- `core_in_size_valid_o`, out, 1; `core_in_size_ready_i`, in, 1; `core_in_size_data_o`, out, `DATA_WIDTH`: size stream to the core.
- `core_out_pel_valid_i`, in, 1; `core_out_pel_ready_o`, out, 1; `core_out_pel_data_i`, in, `DATA_WIDTH`: core results.
- `out_pel_valid_o`, out, 1; `out_pel_ready_i`, in, 1; `out_pel_data_o`, out, `DATA_WIDTH`: results to the sink streamer.

## Operation

State machine has three states: IDLE, RUN, DONE.

**IDLE**
- `eng_ready_o` = 1.
- On `eng_start_i`, latch `cnt_limit_i` into `limit_q` and go to RUN.
- If the latched limit is 0, go to DONE on the next cycle with no traffic.

**RUN**
- Input gating (combinational): `core_in_X_valid_o = in_X_valid_i & eng_enable_i`. `in_X_ready_o = core_in_X_ready_i & eng_enable_i`. Data passes through unregistered. The same rule applies to `in_pel` and `in_size`.
- Core output side: `core_out_pel_ready_o = eng_enable_i & !fifo_full`. A push occurs on `core_out_pel_valid_i & core_out_pel_ready_o`.
- Sink side: `out_pel_valid_o = eng_enable_i & !fifo_empty`. `out_pel_data_o` is the FIFO head. A pop occurs on `out_pel_valid_o & out_pel_ready_i`.
- Each pop increments `cnt_out_pel_o`. When a pop makes the count equal `limit_q`, go to DONE.

**DONE**
- `eng_done_o` pulses high for the first cycle in DONE only.
- Input readies and valids are 0. `out_pel_valid_o` = 0.
- `core_out_pel_ready_o` = 1: surplus core outputs are accepted and discarded, and the FIFO is flushed.
- The count holds at `limit_q`. `eng_ready_o` = 0.
- Leave DONE only via `eng_clear_i`.

**In any state other than RUN:** all input-side readies and valids are 0. The count never exceeds `limit_q`.

**`eng_clear_i`** (any state): next cycle the state is IDLE, the count is 0, the FIFO is empty and `limit_q` is 0. Clear wins over a simultaneous start.

**FIFO:** 2 entries, full throughput.
- Simultaneous push and pop when full is legal: the pop frees the slot.
- Push when full is impossible, because ready is low.
- Data order is strictly preserved.

## Timing
- Reset values: state IDLE; `eng_ready_o` 1; `eng_done_o` 0; `cnt_out_pel_o` 0; FIFO empty; `out_pel_valid_o` 0; `core_out_pel_ready_o` 0; all input readies and core valids 0.
- `eng_ready_o` drops the cycle after start is accepted.
- Core result to `out_pel_valid_o` latency: 1 cycle when the FIFO is empty.
- Counter update: registered, visible the cycle after the pop.
- `eng_done_o`: asserted in the cycle after the final pop, in the same cycle the count first equals the limit.
- `eng_enable_i` low:
  - All handshakes are blocked in that same cycle, since gating is combinational.
  - Counter and FIFO hold.
  - The state does not change, except that `eng_clear_i` still applies.
- Start while in RUN or DONE: ignored.
- Reset mid-job: immediate return to the reset values; buffered data is lost.

## Test plan
- **Basic job:** start with limit = 4, enable = 1, 4 core outputs 0xA..0xD, sink always ready. Required: out_pel carries 0xA..0xD in order; count goes 1..4; `eng_done_o` pulses once in the cycle after the 4th pop; `eng_ready_o` = 0 until clear.
- **Back-pressure:** limit = 6, sink ready low for 5 cycles. Required: FIFO fills at 2 and `core_out_pel_ready_o` = 0; after sink ready rises, all 6 values arrive in order with no loss or duplication; count = 6.
- **Enable stall:** drop `eng_enable_i` for 3 cycles mid-job with valid traffic on every stream. Required: no handshakes occur, count and FIFO hold, and traffic resumes exactly where it stopped.
- **Limit 0:** start with limit = 0. Required: DONE after 1 cycle, `eng_done_o` pulses, count stays 0, no input handshakes.
- **Clear / start conflict:** assert clear and start in the same cycle in IDLE. Required: stays IDLE, `limit_q` = 0. Assert clear mid-RUN with 2 entries buffered. Required: FIFO empty, count 0, IDLE on the next cycle.
- **Async reset:** assert `rst_i` mid-transfer, off the clock edge. Required: all outputs take their reset values immediately; a following start with limit = 2 completes normally.

Source files
------------

// File: rtl/roberts_mdc_engine_ctrl.sv
// Roberts MDC accelerator: engine-side control and stream stage.
// Gates the input streams into the multi-dataflow core, buffers core results in a
// 2-entry FIFO towards the sink streamer, and counts delivered pixels against the job limit.
module roberts_mdc_engine_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  eng_clear_i,
    input  logic                  eng_enable_i,
    input  logic                  eng_start_i,
    input  logic [CNT_WIDTH-1:0]  cnt_limit_i,
    output logic                  eng_ready_o,
    output logic                  eng_done_o,
    output logic [CNT_WIDTH-1:0]  cnt_out_pel_o,
    input  logic                  in_pel_valid_i,
    output logic                  in_pel_ready_o,
    input  logic [DATA_WIDTH-1:0] in_pel_data_i,
    input  logic                  in_size_valid_i,
    output logic                  in_size_ready_o,
    input  logic [DATA_WIDTH-1:0] in_size_data_i,
    output logic                  core_in_pel_valid_o,
    input  logic                  core_in_pel_ready_i,
    output logic [DATA_WIDTH-1:0] core_in_pel_data_o,
    output logic                  core_in_size_valid_o,
    input  logic                  core_in_size_ready_i,
    output logic [DATA_WIDTH-1:0] core_in_size_data_o,
    input  logic                  core_out_pel_valid_i,
    output logic                  core_out_pel_ready_o,
    input  logic [DATA_WIDTH-1:0] core_out_pel_data_i,
    output logic                  out_pel_valid_o,
    input  logic                  out_pel_ready_i,
    output logic [DATA_WIDTH-1:0] out_pel_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  limit_q, limit_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] fifo_mem_q [2];
    logic                  fifo_wr_ptr_q;
    logic                  fifo_rd_ptr_q;
    logic [1:0]            fifo_fill_q;

    logic fifo_full;
    logic fifo_empty;
    logic run_active;
    logic stream_on;
    logic push;
    logic pop;
    logic flush;

    assign fifo_full  = (fifo_fill_q == 2'd2);
    assign fifo_empty = (fifo_fill_q == 2'd0);

    // A zero-limit job passes through RUN for one cycle without moving any traffic.
    assign run_active = (state_q == ST_RUN) && (limit_q != '0);
    assign stream_on  = run_active && eng_enable_i;

    assign core_in_pel_valid_o  = stream_on && in_pel_valid_i;
    assign in_pel_ready_o       = stream_on && core_in_pel_ready_i;
    assign core_in_pel_data_o   = in_pel_data_i;
    assign core_in_size_valid_o = stream_on && in_size_valid_i;
    assign in_size_ready_o      = stream_on && core_in_size_ready_i;
    assign core_in_size_data_o  = in_size_data_i;

    // In DONE the core side is drained: surplus results are accepted and dropped.
    assign core_out_pel_ready_o = (stream_on && !fifo_full) || (state_q == ST_DONE);
    assign out_pel_valid_o      = stream_on && !fifo_empty;
    assign out_pel_data_o       = fifo_mem_q[fifo_rd_ptr_q];

    assign push = stream_on && core_out_pel_valid_i && !fifo_full;
    assign pop  = out_pel_valid_o && out_pel_ready_i;

    assign eng_ready_o   = (state_q == ST_IDLE);
    assign eng_done_o    = done_q;
    assign cnt_out_pel_o = cnt_q;

    // Next-state logic: clear overrides everything, start only honoured while idle and enabled.
    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        flush   = 1'b0;
        if (eng_clear_i) begin
            state_d = ST_IDLE;
            limit_d = '0;
            cnt_d   = '0;
            flush   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (eng_start_i && eng_enable_i) begin
                        limit_d = cnt_limit_i;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (limit_q == '0) begin
                        if (eng_enable_i) begin
                            state_d = ST_DONE;
                        end
                    end else if (pop) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == limit_q) begin
                            state_d = ST_DONE;
                            flush   = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // Control registers: state, latched limit, output count and the done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // FIFO bookkeeping; a flush on job end or clear discards anything still buffered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_fill_q   <= 2'd0;
        end else if (flush) begin
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_fill_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
            end
            if (pop) begin
                fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   fifo_fill_q <= fifo_fill_q + 2'd1;
                2'b01:   fifo_fill_q <= fifo_fill_q - 2'd1;
                default: fifo_fill_q <= fifo_fill_q;
            endcase
        end
    end

    // FIFO storage needs no reset; validity is tracked by the fill level alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[fifo_wr_ptr_q] <= core_out_pel_data_i;
        end
    end

endmodule
